// File: rtl/sbd_fifo_mp.sv
// sbd_fifo_mp: multi-port in-order scoreboard FIFO holding pipeline-tag/PC
// records between issue and commit. Up to NPush entries enter and up to NPop
// entries leave per cycle. The push group is granted all-or-nothing, and the
// oldest NPop entries are always presented as a head window. A flush empties
// the queue in one cycle. Protocol errors leave sticky flags behind.
module sbd_fifo_mp #(
   parameter int Depth = 8,
   parameter int Width = 37,
   parameter int NPush = 2,
   parameter int NPop  = 2,
   parameter int CntW  = $clog2(Depth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NPush-1:0]       push_valid_i,
   input  logic [NPush*Width-1:0] push_data_i,
   output logic                   push_gnt_o,
   input  logic [NPop-1:0]        pop_i,
   output logic [NPop*Width-1:0]  rd_data_o,
   output logic [NPop-1:0]        rd_valid_o,
   input  logic                   flush_i,
   output logic [CntW-1:0]        count_o,
   output logic [CntW-1:0]        free_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [1:0]             err_o
);

   // Depth is a power of two, so pointer arithmetic wraps by truncation.
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   // Lane masks are zero-extended to four bits (the largest lane count)
   // so that one helper serves both ports.
   function automatic logic [2:0] ones4(input logic [3:0] m);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, m[i]};
      end
      return n;
   endfunction

   // A lane mask is contiguous from lane 0 exactly when it has the form 0..01..1.
   // Adding one to such a mask clears all of its set bits.
   function automatic logic contig4(input logic [3:0] m);
      return ((m & (m + 4'd1)) == 4'd0);
   endfunction

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  rd_ptr;
   logic [PtrW-1:0]  wr_ptr;
   logic [CntW-1:0]  count;
   logic [1:0]       err;

   logic [CntW-1:0]  npush;
   logic [CntW-1:0]  npop;
   logic [CntW-1:0]  free;
   logic             push_contig;
   logic             pop_contig;
   logic             push_gnt;
   logic             pop_legal;
   logic             pop_under;
   logic [PtrW-1:0]  wr_addr [NPush];
   logic [NPush-1:0] wr_en;

   // Decode lane requests. Grant and legality are judged against the
   // occupancy at the start of the cycle, so same-cycle pops never make
   // room for a push.
   always_comb begin
      npush       = CntW'(ones4(4'(push_valid_i)));
      npop        = CntW'(ones4(4'(pop_i)));
      push_contig = contig4(4'(push_valid_i));
      pop_contig  = contig4(4'(pop_i));
      free        = CntW'(Depth) - count;
      push_gnt    = push_contig && (npush != '0) && (npush <= free) && !flush_i;
      pop_legal   = pop_contig && (npop <= count) && !flush_i;
      pop_under   = pop_contig && (npop > count) && !flush_i;
   end

   // Each granted lane k writes at wr_ptr+k. A group may wrap past the end of the array.
   always_comb begin
      for (int k = 0; k < NPush; k++) begin
         wr_addr[k] = wr_ptr + PtrW'(k);
         wr_en[k]   = push_gnt && push_valid_i[k];
      end
   end

   // Storage array. Its contents are not reset, and stale data is masked by rd_valid_o.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NPush; k++) begin
         if (wr_en[k]) begin
            mem[wr_addr[k]] <= push_data_i[k*Width +: Width];
         end
      end
   end

   // Pointers and occupancy. Reset beats flush, and flush beats normal traffic.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_gnt) begin
            wr_ptr <= wr_ptr + PtrW'(npush);
         end
         if (pop_legal) begin
            rd_ptr <= rd_ptr + PtrW'(npop);
         end
         count <= count + (push_gnt ? npush : '0) - (pop_legal ? npop : '0);
      end
   end

   // Sticky error flags: [0] popping more than is held, [1] a gap in a lane mask.
   // Flush ignores both ports, so a flush cycle never raises a flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err <= 2'b00;
      end else if (!flush_i) begin
         err[0] <= err[0] | pop_under;
         err[1] <= err[1] | !push_contig | !pop_contig;
      end
   end

   // Head window: lane k shows the k-th-oldest entry and is valid while count exceeds k.
   always_comb begin
      for (int k = 0; k < NPop; k++) begin
         rd_data_o[k*Width +: Width] = mem[rd_ptr + PtrW'(k)];
         rd_valid_o[k]               = (count > CntW'(k));
      end
   end

   // Status outputs are taken from registered state. The grant is the only combinational path.
   always_comb begin
      push_gnt_o = push_gnt;
      count_o    = count;
      free_o     = free;
      full_o     = (count == CntW'(Depth));
      empty_o    = (count == '0);
      err_o      = err;
   end

endmodule

// File: tb/tb_sbd_fifo_mp.sv
// tb_sbd_fifo_mp: directed scenarios plus a randomized run for sbd_fifo_mp,
// compared against a queue-based reference of the FIFO rules.
module tb_sbd_fifo_mp;

   localparam int DEPTH = 8;
   localparam int W     = 37;

   logic          clk_i;
   logic          rst_i;
   logic [1:0]    push_valid_i;
   logic [2*W-1:0] push_data_i;
   logic          push_gnt_o;
   logic [1:0]    pop_i;
   logic [2*W-1:0] rd_data_o;
   logic [1:0]    rd_valid_o;
   logic          flush_i;
   logic [3:0]    count_o;
   logic [3:0]    free_o;
   logic          full_o;
   logic          empty_o;
   logic [1:0]    err_o;

   int total;
   int bad;

   logic [W-1:0] q[$];
   logic [1:0]   merr;
   logic         obs_gnt;
   logic         exp_gnt;

   sbd_fifo_mp #(.Depth(DEPTH), .Width(W), .NPush(2), .NPop(2)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push_valid_i(push_valid_i),
      .push_data_i(push_data_i),
      .push_gnt_o(push_gnt_o),
      .pop_i(pop_i),
      .rd_data_o(rd_data_o),
      .rd_valid_o(rd_valid_o),
      .flush_i(flush_i),
      .count_o(count_o),
      .free_o(free_o),
      .full_o(full_o),
      .empty_o(empty_o),
      .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] rnd37();
      logic [63:0] x;
      x = {$urandom(), $urandom()};
      return x[W-1:0];
   endfunction

   function automatic bit mask_ok(input logic [1:0] m);
      int n;
      n = $countones(m);
      return (int'(m) == (2**n) - 1);
   endfunction

   function automatic logic model_gnt(input logic [1:0] pv, input logic fl);
      int n;
      n = $countones(pv);
      return !fl && mask_ok(pv) && (n > 0) && (n <= DEPTH - q.size());
   endfunction

   task automatic model_update(input logic [1:0] pv, input logic [2*W-1:0] pd,
                               input logic [1:0] pp, input logic fl);
      logic g;
      int np;
      g = model_gnt(pv, fl);
      if (fl) begin
         q.delete();
      end else begin
         np = $countones(pp);
         if (!mask_ok(pv) || !mask_ok(pp)) merr[1] = 1'b1;
         if (mask_ok(pp)) begin
            if (np > q.size()) merr[0] = 1'b1;
            else repeat (np) void'(q.pop_front());
         end
         if (g) begin
            for (int k = 0; k < $countones(pv); k++) q.push_back(pd[k*W +: W]);
         end
      end
   endtask

   // One clock cycle: apply inputs, sample the grant mid-cycle, then clock and update the model.
   task automatic drive(input logic [1:0] pv, input logic [2*W-1:0] pd,
                        input logic [1:0] pp, input logic fl);
      push_valid_i = pv;
      push_data_i  = pd;
      pop_i        = pp;
      flush_i      = fl;
      #3;
      obs_gnt = push_gnt_o;
      exp_gnt = model_gnt(pv, fl);
      @(posedge clk_i);
      model_update(pv, pd, pp, fl);
      #1;
   endtask

   task automatic do_reset();
      rst_i        = 1'b1;
      push_valid_i = 2'b00;
      pop_i        = 2'b00;
      flush_i      = 1'b0;
      push_data_i  = '0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      q.delete();
      merr = 2'b00;
   endtask

   task automatic test_reset();
      do_reset();
      #3;
      total++; if (push_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt got=%b want=0", push_gnt_o); end
      total++; if (count_o !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count_o); end
      total++; if (free_o !== 4'd8) begin bad++; $display("[TB] FAIL reset_free got=%0d want=8", free_o); end
      total++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags empty=%b full=%b want 1/0", empty_o, full_o); end
      total++; if (rd_valid_o !== 2'b00) begin bad++; $display("[TB] FAIL reset_rdvalid got=%b want=00", rd_valid_o); end
      total++; if (err_o !== 2'b00) begin bad++; $display("[TB] FAIL reset_err got=%b want=00", err_o); end
   endtask

   task automatic test_push_pair();
      logic [W-1:0] a, b;
      do_reset();
      a = rnd37(); b = rnd37();
      drive(2'b11, {b, a}, 2'b00, 1'b0);
      total++; if (obs_gnt !== 1'b1) begin bad++; $display("[TB] FAIL pair_gnt got=%b want=1", obs_gnt); end
      total++; if (rd_valid_o !== 2'b11) begin bad++; $display("[TB] FAIL pair_rdvalid got=%b want=11", rd_valid_o); end
      total++; if (rd_data_o[0 +: W] !== a) begin bad++; $display("[TB] FAIL pair_lane0 got=%h want=%h", rd_data_o[0 +: W], a); end
      total++; if (rd_data_o[W +: W] !== b) begin bad++; $display("[TB] FAIL pair_lane1 got=%h want=%h", rd_data_o[W +: W], b); end
      total++; if (count_o !== 4'd2) begin bad++; $display("[TB] FAIL pair_count got=%0d want=2", count_o); end
   endtask

   task automatic test_full_refuse();
      logic [W-1:0] first;
      do_reset();
      first = rnd37();
      drive(2'b11, {rnd37(), first}, 2'b00, 1'b0);
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b01, {rnd37(), rnd37()}, 2'b00, 1'b0);
      total++; if (count_o !== 4'd7) begin bad++; $display("[TB] FAIL full_fill7 got=%0d want=7", count_o); end
      drive(2'b11, {rnd37(), rnd37()}, 2'b01, 1'b0);
      total++; if (obs_gnt !== 1'b0) begin bad++; $display("[TB] FAIL full_nobypass_gnt got=%b want=0", obs_gnt); end
      total++; if (count_o !== 4'd6) begin bad++; $display("[TB] FAIL full_after_pop got=%0d want=6", count_o); end
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      total++; if (obs_gnt !== 1'b1) begin bad++; $display("[TB] FAIL full_retry_gnt got=%b want=1", obs_gnt); end
      total++; if (count_o !== 4'd8 || full_o !== 1'b1 || free_o !== 4'd0) begin bad++; $display("[TB] FAIL full_state count=%0d full=%b free=%0d want 8/1/0", count_o, full_o, free_o); end
      total++; if (rd_data_o[0 +: W] !== q[0]) begin bad++; $display("[TB] FAIL full_head got=%h want=%h", rd_data_o[0 +: W], q[0]); end
      drive(2'b01, {rnd37(), rnd37()}, 2'b00, 1'b0);
      total++; if (obs_gnt !== 1'b0) begin bad++; $display("[TB] FAIL full_push_when_full got=%b want=0", obs_gnt); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] c, d;
      do_reset();
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b01, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b00, '0, 2'b11, 1'b0);
      drive(2'b00, '0, 2'b11, 1'b0);
      drive(2'b00, '0, 2'b01, 1'b0);
      total++; if (empty_o !== 1'b1) begin bad++; $display("[TB] FAIL wrap_drained got=%b want=1", empty_o); end
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      c = rnd37(); d = rnd37();
      drive(2'b11, {d, c}, 2'b00, 1'b0);
      total++; if (obs_gnt !== 1'b1) begin bad++; $display("[TB] FAIL wrap_gnt got=%b want=1", obs_gnt); end
      drive(2'b00, '0, 2'b11, 1'b0);
      total++; if (count_o !== 4'd2) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=2", count_o); end
      total++; if (rd_data_o[0 +: W] !== c) begin bad++; $display("[TB] FAIL wrap_lane0 got=%h want=%h", rd_data_o[0 +: W], c); end
      total++; if (rd_data_o[W +: W] !== d) begin bad++; $display("[TB] FAIL wrap_lane1 got=%h want=%h", rd_data_o[W +: W], d); end
   endtask

   task automatic test_underflow();
      logic [W-1:0] old, e;
      do_reset();
      total++; if (err_o !== 2'b00) begin bad++; $display("[TB] FAIL under_pre_err got=%b want=00", err_o); end
      old = rnd37(); e = rnd37();
      drive(2'b01, {rnd37(), old}, 2'b00, 1'b0);
      drive(2'b01, {rnd37(), e}, 2'b11, 1'b0);
      total++; if (obs_gnt !== 1'b1) begin bad++; $display("[TB] FAIL under_gnt got=%b want=1", obs_gnt); end
      total++; if (count_o !== 4'd2) begin bad++; $display("[TB] FAIL under_count got=%0d want=2", count_o); end
      total++; if (err_o !== 2'b01) begin bad++; $display("[TB] FAIL under_err got=%b want=01", err_o); end
      total++; if (rd_data_o[0 +: W] !== old || rd_data_o[W +: W] !== e) begin bad++; $display("[TB] FAIL under_lanes got=%h/%h want=%h/%h", rd_data_o[0 +: W], rd_data_o[W +: W], old, e); end
      drive(2'b00, '0, 2'b00, 1'b0);
      drive(2'b00, '0, 2'b01, 1'b0);
      drive(2'b00, '0, 2'b00, 1'b1);
      total++; if (err_o !== 2'b01) begin bad++; $display("[TB] FAIL under_sticky got=%b want=01", err_o); end
      do_reset();
      total++; if (err_o !== 2'b00) begin bad++; $display("[TB] FAIL under_cleared got=%b want=00", err_o); end
   endtask

   task automatic test_flush();
      logic [W-1:0] f;
      do_reset();
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b01, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b11, {rnd37(), rnd37()}, 2'b11, 1'b1);
      total++; if (obs_gnt !== 1'b0) begin bad++; $display("[TB] FAIL flush_gnt got=%b want=0", obs_gnt); end
      total++; if (count_o !== 4'd0 || empty_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_state count=%0d empty=%b want 0/1", count_o, empty_o); end
      total++; if (err_o !== 2'b00) begin bad++; $display("[TB] FAIL flush_err got=%b want=00", err_o); end
      f = rnd37();
      drive(2'b01, {rnd37(), f}, 2'b00, 1'b0);
      total++; if (obs_gnt !== 1'b1) begin bad++; $display("[TB] FAIL flush_repush_gnt got=%b want=1", obs_gnt); end
      total++; if (rd_valid_o !== 2'b01 || rd_data_o[0 +: W] !== f) begin bad++; $display("[TB] FAIL flush_head valid=%b data=%h want 01/%h", rd_valid_o, rd_data_o[0 +: W], f); end
   endtask

   task automatic test_noncontig();
      do_reset();
      drive(2'b11, {rnd37(), rnd37()}, 2'b00, 1'b0);
      drive(2'b10, {rnd37(), rnd37()}, 2'b00, 1'b0);
      total++; if (obs_gnt !== 1'b0) begin bad++; $display("[TB] FAIL gap_push_gnt got=%b want=0", obs_gnt); end
      total++; if (count_o !== 4'd2 || err_o !== 2'b10) begin bad++; $display("[TB] FAIL gap_push count=%0d err=%b want 2/10", count_o, err_o); end
      drive(2'b00, '0, 2'b10, 1'b0);
      total++; if (count_o !== 4'd2 || err_o !== 2'b10) begin bad++; $display("[TB] FAIL gap_pop count=%0d err=%b want 2/10", count_o, err_o); end
   endtask

   function automatic logic [1:0] pick_mask();
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) return 2'b00;
      if (r < 6) return 2'b01;
      if (r < 9) return 2'b11;
      return 2'b10;
   endfunction

   task automatic test_random();
      logic [1:0] pv, pp;
      logic       fl;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         pv = pick_mask();
         pp = pick_mask();
         fl = ($urandom_range(0, 24) == 0);
         drive(pv, {rnd37(), rnd37()}, pp, fl);
         total++; if (obs_gnt !== exp_gnt) begin bad++; $display("[TB] FAIL rnd_gnt cyc=%0d got=%b want=%b", i, obs_gnt, exp_gnt); end
         total++; if (count_o !== q.size() || free_o !== DEPTH - q.size()) begin bad++; $display("[TB] FAIL rnd_count cyc=%0d count=%0d free=%0d want=%0d", i, count_o, free_o, q.size()); end
         total++; if (full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0)) begin bad++; $display("[TB] FAIL rnd_flags cyc=%0d full=%b empty=%b size=%0d", i, full_o, empty_o, q.size()); end
         total++; if (err_o !== merr) begin bad++; $display("[TB] FAIL rnd_err cyc=%0d got=%b want=%b", i, err_o, merr); end
         for (int k = 0; k < 2; k++) begin
            total++; if (rd_valid_o[k] !== (q.size() > k)) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d lane=%0d got=%b", i, k, rd_valid_o[k]); end
            if (k < q.size()) begin
               total++; if (rd_data_o[k*W +: W] !== q[k]) begin bad++; $display("[TB] FAIL rnd_data cyc=%0d lane=%0d got=%h want=%h", i, k, rd_data_o[k*W +: W], q[k]); end
            end
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      merr  = 2'b00;
      rst_i = 1'b1;
      push_valid_i = 2'b00;
      push_data_i  = '0;
      pop_i   = 2'b00;
      flush_i = 1'b0;
      @(posedge clk_i);
      #1;
      test_reset();
      test_push_pair();
      test_full_refuse();
      test_wrap();
      test_underflow();
      test_flush();
      test_noncontig();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
